// File: rtl/pipe_pkg.sv
// Shared constants and types for the write-back pipeline stage register.
//   CTRL_W_DEF / DATA_W_DEF / ADDR_W_DEF : default field widths
//   payload_t : packed {ctrl, data, addr} payload at the default widths
package pipe_pkg;

  localparam int CTRL_W_DEF = 2;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef struct packed {
    logic [CTRL_W_DEF-1:0] ctrl;
    logic [DATA_W_DEF-1:0] data;
    logic [ADDR_W_DEF-1:0] addr;
  } payload_t;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot: a valid bit plus a payload register.
//   clk, r_n          : clock, asynchronous active-low reset
//   i_load / i_clear  : load i_data (sets valid) / empty the slot and zero the payload
//   i_data            : payload to load
//   o_valid / o_data  : registered slot contents
// Clear wins over load, so a kill in the same cycle as a load leaves the slot empty.
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         r_n,
  input  logic         i_load,
  input  logic         i_clear,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register for the write-back path.
//   clk, r_n                       : clock, asynchronous active-low reset
//   flush                          : synchronous kill of every held entry
//   in_valid/in_ready, in_*        : upstream handshake and payload
//   out_valid/out_ready, out_*     : downstream handshake and head payload
//   count                          : number of held entries (0..2)
// SKID=1: head + skid slot, in_ready registered (= !skid_valid), so no
//         ready path runs combinationally from downstream to upstream.
// SKID=0: head only, in_ready = !out_valid | out_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              r_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic [1:0]        count
);

  localparam int PW = CTRL_W + DATA_W + ADDR_W;

  logic          w_head_v;
  logic [PW-1:0] w_head_pl;
  logic          w_skid_v;
  logic [PW-1:0] w_skid_pl;
  logic [PW-1:0] w_in_pl;
  logic [PW-1:0] w_out_pl;
  logic          w_acc;
  logic          w_cons;
  logic          w_head_free;
  logic          w_head_load;
  logic          w_head_clear;
  logic [PW-1:0] w_head_din;

  assign w_in_pl = {in_ctrl, in_data, in_addr};

  assign in_ready = (SKID != 0) ? !w_skid_v : (!w_head_v || out_ready);

  assign w_acc       = in_valid && in_ready;
  assign w_cons      = w_head_v && out_ready;
  assign w_head_free = !w_head_v || w_cons;

  // A free head refills from the skid slot first to preserve order;
  // with nothing to load it empties so stale payload never lingers.
  assign w_head_load  = w_head_free && (w_skid_v || w_acc);
  assign w_head_clear = flush || (w_head_free && !w_skid_v && !w_acc);
  assign w_head_din   = w_skid_v ? w_skid_pl : w_in_pl;

  pipe_slot #(.W(PW)) u_head (
    .clk     (clk),
    .r_n     (r_n),
    .i_load  (w_head_load),
    .i_clear (w_head_clear),
    .i_data  (w_head_din),
    .o_valid (w_head_v),
    .o_data  (w_head_pl)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic w_skid_load;
      logic w_skid_clear;

      // Accept while the head is stuck parks the entry in the skid slot.
      // An accept never coincides with a valid skid slot (in_ready is low).
      assign w_skid_load  = w_acc && !w_head_free;
      assign w_skid_clear = flush || (w_skid_v && w_head_free);

      pipe_slot #(.W(PW)) u_skid (
        .clk     (clk),
        .r_n     (r_n),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_data  (w_in_pl),
        .o_valid (w_skid_v),
        .o_data  (w_skid_pl)
      );
    end else begin : g_no_skid
      assign w_skid_v  = 1'b0;
      assign w_skid_pl = '0;
    end
  endgenerate

  // Bubbles are forced to zero so no write-back control bit leaks out.
  assign w_out_pl  = w_head_pl & {PW{w_head_v}};
  assign out_valid = w_head_v;
  assign {out_ctrl, out_data, out_addr} = w_out_pl;

  assign count = {1'b0, w_head_v} + {1'b0, w_skid_v};

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        r_n = 1'b0;

  logic        a_flush = 1'b0, a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0;
  logic [1:0]  a_in_ctrl = '0, a_out_ctrl, a_count;
  logic [31:0] a_in_data = '0, a_out_data;
  logic [4:0]  a_in_addr = '0, a_out_addr;

  logic        b_flush = 1'b0, b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0;
  logic [1:0]  b_in_ctrl = '0, b_out_ctrl, b_count;
  logic [31:0] b_in_data = '0, b_out_data;
  logic [4:0]  b_in_addr = '0, b_out_addr;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(2), .DATA_W(32), .ADDR_W(5), .SKID(1)) u_dut_a (
    .clk(clk), .r_n(r_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_ctrl(a_in_ctrl), .in_data(a_in_data), .in_addr(a_in_addr),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_ctrl(a_out_ctrl), .out_data(a_out_data), .out_addr(a_out_addr),
    .count(a_count)
  );

  pipe_stage_reg #(.CTRL_W(2), .DATA_W(32), .ADDR_W(5), .SKID(0)) u_dut_b (
    .clk(clk), .r_n(r_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_ctrl(b_in_ctrl), .in_data(b_in_data), .in_addr(b_in_addr),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_ctrl(b_out_ctrl), .out_data(b_out_data), .out_addr(b_out_addr),
    .count(b_count)
  );

  function automatic logic [1:0] mk_ctrl(input logic [31:0] d);
    return d[1:0] | 2'b01;
  endfunction

  function automatic logic [4:0] mk_addr(input logic [31:0] d);
    return d[4:0] ^ 5'h1F;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input logic v, input logic [31:0] d);
    a_in_valid = v;
    a_in_data  = d;
    a_in_ctrl  = mk_ctrl(d);
    a_in_addr  = mk_addr(d);
  endtask

  task automatic drive_b(input logic v, input logic [31:0] d);
    b_in_valid = v;
    b_in_data  = d;
    b_in_ctrl  = mk_ctrl(d);
    b_in_addr  = mk_addr(d);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    #1;
    chk("rst_a_valid", a_out_valid, 0);
    chk("rst_a_data",  a_out_data, 0);
    chk("rst_a_count", a_count, 0);
    chk("rst_a_ready", a_in_ready, 1);
    chk("rst_b_count", b_count, 0);
    #1 r_n = 1'b1;

    // load an entry, then reset asynchronously between edges
    drive_a(1'b1, 32'h77);
    a_out_ready = 1'b0;
    tick();
    chk("pre_rst_valid", a_out_valid, 1);
    chk("pre_rst_data",  a_out_data, 32'h77);
    drive_a(1'b0, 32'h0);
    #2 r_n = 1'b0;
    #1;
    chk("arst_valid", a_out_valid, 0);
    chk("arst_data",  a_out_data, 0);
    chk("arst_ctrl",  a_out_ctrl, 0);
    chk("arst_count", a_count, 0);
    chk("arst_ready", a_in_ready, 1);
    #1 r_n = 1'b1;

    // streaming, first accept on the first edge after release
    a_out_ready = 1'b1;
    drive_a(1'b1, 32'h11);
    tick();
    chk("str_d11",  a_out_data, 32'h11);
    chk("str_c11",  a_out_ctrl, mk_ctrl(32'h11));
    chk("str_a11",  a_out_addr, mk_addr(32'h11));
    chk("str_n11",  a_count, 1);
    drive_a(1'b1, 32'h22);
    tick();
    chk("str_d22",  a_out_data, 32'h22);
    chk("str_n22",  a_count, 1);
    drive_a(1'b1, 32'h33);
    tick();
    chk("str_d33",  a_out_data, 32'h33);
    chk("str_n33",  a_count, 1);
    drive_a(1'b0, 32'h0);
    tick();
    chk("str_empty_v", a_out_valid, 0);
    chk("str_empty_d", a_out_data, 0);
    chk("str_empty_c", a_out_ctrl, 0);

    // backpressure into the skid slot
    a_out_ready = 1'b0;
    drive_a(1'b1, 32'hA);
    tick();
    chk("bp_n1",     a_count, 1);
    chk("bp_rdy1",   a_in_ready, 1);
    drive_a(1'b1, 32'hB);
    tick();
    chk("bp_n2",     a_count, 2);
    chk("bp_rdy2",   a_in_ready, 0);
    chk("bp_head",   a_out_data, 32'hA);
    drive_a(1'b0, 32'h0);
    a_out_ready = 1'b1;
    tick();
    chk("bp_dB",     a_out_data, 32'hB);
    chk("bp_n3",     a_count, 1);
    chk("bp_rdy3",   a_in_ready, 1);
    tick();
    chk("bp_drain_v", a_out_valid, 0);
    chk("bp_drain_n", a_count, 0);

    // flush with both slots full and a new offer
    a_out_ready = 1'b0;
    drive_a(1'b1, 32'hA);
    tick();
    drive_a(1'b1, 32'hB);
    tick();
    chk("fl_pre_n", a_count, 2);
    a_flush = 1'b1;
    drive_a(1'b1, 32'hC);
    tick();
    a_flush = 1'b0;
    chk("fl_n",    a_count, 0);
    chk("fl_v",    a_out_valid, 0);
    chk("fl_c",    a_out_ctrl, 0);
    chk("fl_d",    a_out_data, 0);
    drive_a(1'b0, 32'h0);
    a_out_ready = 1'b1;
    tick();
    chk("fl_noC_v", a_out_valid, 0);
    chk("fl_noC_n", a_count, 0);

    // single-entry mode
    b_out_ready = 1'b0;
    drive_b(1'b1, 32'h55);
    tick();
    chk("s0_n1",   b_count, 1);
    chk("s0_d55",  b_out_data, 32'h55);
    chk("s0_rdy0", b_in_ready, 0);
    b_out_ready = 1'b1;
    #1;
    chk("s0_rdy1", b_in_ready, 1);
    drive_b(1'b1, 32'h66);
    tick();
    chk("s0_d66",  b_out_data, 32'h66);
    chk("s0_n2",   b_count, 1);
    drive_b(1'b0, 32'h0);
    tick();
    chk("s0_empty", b_out_valid, 0);

    // random traffic against a queue model, both modes
    for (int i = 0; i < 2500; i++) begin
      logic        acc_a, cons_a, acc_b, cons_b;
      logic [31:0] da, db;
      da = $urandom;
      db = $urandom;
      drive_a(1'($urandom_range(0, 1)), da);
      drive_b(1'($urandom_range(0, 1)), db);
      a_out_ready = ($urandom_range(0, 2) != 0);
      b_out_ready = ($urandom_range(0, 2) != 0);
      a_flush     = ($urandom_range(0, 31) == 0);
      b_flush     = ($urandom_range(0, 31) == 0);
      #1;
      chk("rnd_a_n",   a_count, 64'(qa.size()));
      chk("rnd_a_rdy", a_in_ready, (qa.size() < 2));
      chk("rnd_a_v",   a_out_valid, (qa.size() != 0));
      if (qa.size() != 0) begin
        chk("rnd_a_d", a_out_data, qa[0]);
        chk("rnd_a_c", a_out_ctrl, mk_ctrl(qa[0]));
      end else begin
        chk("rnd_a_c0", a_out_ctrl, 0);
      end
      chk("rnd_b_n",   b_count, 64'(qb.size()));
      chk("rnd_b_rdy", b_in_ready, (qb.size() == 0) || b_out_ready);
      if (qb.size() != 0) chk("rnd_b_d", b_out_data, qb[0]);
      else                chk("rnd_b_c0", b_out_ctrl, 0);
      acc_a  = a_in_valid && (qa.size() < 2);
      cons_a = a_out_ready && (qa.size() != 0);
      acc_b  = b_in_valid && ((qb.size() == 0) || b_out_ready);
      cons_b = b_out_ready && (qb.size() != 0);
      @(posedge clk);
      if (a_flush) qa.delete();
      else begin
        if (cons_a) void'(qa.pop_front());
        if (acc_a)  qa.push_back(da);
      end
      if (b_flush) qb.delete();
      else begin
        if (cons_b) void'(qb.pop_front());
        if (acc_b)  qb.push_back(db);
      end
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
